pm_responder: RTL and testbench

//  Program-memory responder on the far side of the fetch PM interface: answers o_PMADDR with
//  i_PMDATA words for the fetch stage. Also owns a byte-stream boot loader (valid/ready) that

---
 rtl/pm_pkg.sv | 29 ++
 rtl/pm_ram.sv | 45 ++++
 rtl/pm_responder.sv | 201 ++++++++++++++++++++
 tb/tb_pm_responder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pm_pkg.sv
// ---------------------------------------------------------------------------
// pm_pkg
//   Shared types and constants for the program-memory responder.
//   - pm_state_t   : boot-loader session states
//   - PM_DATA_W    : program-memory word width (16)
//   - PM_NOP_WORD  : default word returned to fetch while a load is running
//   - pm_ld_ready(): states in which the loader accepts a byte
// ---------------------------------------------------------------------------
package pm_pkg;

    localparam int          PM_DATA_W   = 16;
    localparam logic [15:0] PM_NOP_WORD = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DAT_LO = 3'd3,
        ST_DAT_HI = 3'd4,
        ST_DONE   = 3'd5
    } pm_state_t;

    // The loader consumes bytes only while assembling the length or a data word.
    function automatic logic pm_ld_ready(input pm_state_t s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DAT_LO) || (s == ST_DAT_HI);
    endfunction

endpackage

// File: rtl/pm_ram.sv
// ---------------------------------------------------------------------------
// pm_ram
//   Simple dual-port synchronous RAM, DEPTH = 2**ADDR_W words of DATA_W bits.
//   One write port, one read port with a registered output (1-clock latency).
//   Contents are never cleared; a read of the address being written in the
//   same cycle returns the old word.
// Ports
//   i_clk    in   1        clock, rising edge
//   i_we     in   1        write enable
//   i_waddr  in   ADDR_W   write word address
//   i_wdata  in   DATA_W   write data
//   i_raddr  in   ADDR_W   read word address
//   o_rdata  out  DATA_W   read data, registered
// ---------------------------------------------------------------------------
module pm_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_p1;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // ---- read stage p0 -> p1 ----
    always_ff @(posedge i_clk) begin
        r_rdata_p1 <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/pm_responder.sv
// ---------------------------------------------------------------------------
// pm_responder
//   Program-memory responder for the fetch stage plus a byte-stream boot
//   loader. Fetches are answered one clock after the address is presented;
//   while a load session is active every fetch is answered with NOP_WORD.
//   Load stream: length low byte, length high byte, then per word low byte
//   followed by high byte. A length above DEPTH aborts with a sticky error.
// Ports
//   i_clk       in   1         clock, rising edge
//   i_reset     in   1         synchronous, active-high reset
//   i_PMADDR    in   16        fetch word address (wraps modulo DEPTH)
//   o_PMDATA    out  16        fetched word, 1-clock latency
//   i_ld_start  in   1         pulse: begin a load session (ignored if busy)
//   i_ld_valid  in   1         loader byte valid
//   i_ld_byte   in   8         loader byte
//   o_ld_ready  out  1         a byte is accepted this cycle if valid
//   o_ld_busy   out  1         load session active
//   o_ld_done   out  1         one-cycle pulse on successful completion
//   o_ld_err    out  1         sticky: length exceeded DEPTH
//   o_ld_count  out  ADDR_W+1  words written in current/last session
// ---------------------------------------------------------------------------
module pm_responder
    import pm_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter logic [15:0] NOP_WORD = PM_NOP_WORD
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [15:0]       i_PMADDR,
    output logic [15:0]       o_PMDATA,
    input  logic              i_ld_start,
    input  logic              i_ld_valid,
    input  logic [7:0]        i_ld_byte,
    output logic              o_ld_ready,
    output logic              o_ld_busy,
    output logic              o_ld_done,
    output logic              o_ld_err,
    output logic [ADDR_W:0]   o_ld_count
);

    localparam int          CNT_W   = ADDR_W + 1;
    localparam logic [16:0] DEPTH_L = 17'(2 ** ADDR_W);

    pm_state_t r_state;
    pm_state_t w_state_nxt;

    logic [15:0]          r_len;
    logic [ADDR_W-1:0]    r_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [7:0]           r_lo;
    logic                 r_err;
    logic                 r_vld_p1;
    logic                 r_nop_p1;

    logic                 w_xfer;
    logic                 w_we;
    logic [15:0]          w_len_asm;
    logic                 w_len_too_big;
    logic [CNT_W-1:0]     w_count_inc;
    logic                 w_last_word;
    logic [15:0]          w_ram_rdata;
    logic                 w_unused_addr;

    assign o_ld_ready = pm_ld_ready(r_state);
    assign o_ld_busy  = (r_state != ST_IDLE);
    assign o_ld_done  = (r_state == ST_DONE);
    assign o_ld_err   = r_err;
    assign o_ld_count = r_count;

    assign w_xfer        = i_ld_valid & o_ld_ready;
    // Full length as it will be once the high byte on the bus is taken.
    assign w_len_asm     = {i_ld_byte, r_len[7:0]};
    assign w_len_too_big = ({1'b0, w_len_asm} > DEPTH_L);
    assign w_count_inc   = r_count + CNT_W'(1);
    assign w_last_word   = (17'(w_count_inc) == {1'b0, r_len});

    // Upper fetch-address bits are deliberately ignored (address wraps).
    assign w_unused_addr = ^i_PMADDR[15:ADDR_W];

    always_comb begin
        w_state_nxt = r_state;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_ld_start) begin
                    w_state_nxt = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (w_xfer) begin
                    w_state_nxt = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (w_xfer) begin
                    if (w_len_asm == 16'd0) begin
                        w_state_nxt = ST_DONE;
                    end else if (w_len_too_big) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DAT_LO;
                    end
                end
            end
            ST_DAT_LO: begin
                if (w_xfer) begin
                    w_state_nxt = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                if (w_xfer) begin
                    w_we        = 1'b1;
                    w_state_nxt = w_last_word ? ST_DONE : ST_DAT_LO;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_len    <= 16'd0;
            r_ptr    <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
            r_vld_p1 <= 1'b0;
            r_nop_p1 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_vld_p1 <= 1'b1;
            // NOP forcing follows the busy flag of the cycle the read was issued.
            r_nop_p1 <= o_ld_busy;
            case (r_state)
                ST_IDLE: begin
                    if (i_ld_start) begin
                        r_err   <= 1'b0;
                        r_ptr   <= '0;
                        r_count <= '0;
                    end
                end
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= i_ld_byte;
                    end
                end
                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len[15:8] <= i_ld_byte;
                        if (w_len_too_big) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_DAT_HI: begin
                    if (w_xfer) begin
                        r_ptr   <= r_ptr + ADDR_W'(1);
                        r_count <= w_count_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Low data byte is pure datapath; it is always rewritten before use.
    always_ff @(posedge i_clk) begin
        if ((r_state == ST_DAT_LO) && w_xfer) begin
            r_lo <= i_ld_byte;
        end
    end

    pm_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (PM_DATA_W)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_we),
        .i_waddr (r_ptr),
        .i_wdata ({i_ld_byte, r_lo}),
        .i_raddr (i_PMADDR[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // ---- read stage p1: output select ----
    // Before the first post-reset read completes the output is held at zero.
    always_comb begin
        o_PMDATA = 16'd0;
        if (r_vld_p1) begin
            o_PMDATA = r_nop_p1 ? NOP_WORD : w_ram_rdata;
        end
    end

endmodule

// File: tb/tb_pm_responder.sv
module tb_pm_responder;
    import pm_pkg::*;

    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              i_reset;
    logic [15:0]       i_PMADDR;
    logic [15:0]       o_PMDATA;
    logic              i_ld_start;
    logic              i_ld_valid;
    logic [7:0]        i_ld_byte;
    logic              o_ld_ready;
    logic              o_ld_busy;
    logic              o_ld_done;
    logic              o_ld_err;
    logic [ADDR_W:0]   o_ld_count;

    int n_vec    = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic mon_en   = 1'b0;
    logic mon_prev = 1'b0;

    always #5 clk = ~clk;

    pm_responder #(.ADDR_W(ADDR_W), .NOP_WORD(16'h0000)) dut (
        .i_clk      (clk),
        .i_reset    (i_reset),
        .i_PMADDR   (i_PMADDR),
        .o_PMDATA   (o_PMDATA),
        .i_ld_start (i_ld_start),
        .i_ld_valid (i_ld_valid),
        .i_ld_byte  (i_ld_byte),
        .o_ld_ready (o_ld_ready),
        .o_ld_busy  (o_ld_busy),
        .o_ld_done  (o_ld_done),
        .o_ld_err   (o_ld_err),
        .o_ld_count (o_ld_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        i_ld_start = 1'b1;
        tick();
        i_ld_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int   cyc;
        logic acc;
        cyc = 0;
        acc = 1'b0;
        i_ld_valid = 1'b1;
        i_ld_byte  = b;
        while (!acc && cyc < 20) begin
            @(negedge clk);
            acc = o_ld_ready;
            tick();
            cyc++;
        end
        i_ld_valid = 1'b0;
        if (!acc) check("xfer_timeout", 32'(acc), 32'd1);
    endtask

    task automatic fetch(input string tag, input logic [15:0] a, input logic [15:0] exp);
        i_PMADDR = a;
        tick();
        check(tag, 32'(o_PMDATA), 32'(exp));
    endtask

    // While a read was issued with busy high, the answer must be NOP.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mon_prev) check("nop_while_busy", 32'(o_PMDATA), 32'h0000);
            mon_prev = o_ld_busy;
        end
    end

    always @(negedge clk) begin
        if (o_ld_done) done_cnt++;
    end

    initial begin
        logic [15:0] img [6];
        img[0] = 16'hA5A5; img[1] = 16'h0001; img[2] = 16'h0002;
        img[3] = 16'h0003; img[4] = 16'h0004; img[5] = 16'h940C;

        i_reset = 1'b1; i_PMADDR = 16'd0; i_ld_start = 1'b0;
        i_ld_valid = 1'b0; i_ld_byte = 8'd0;
        repeat (3) tick();
        check("rst_pmdata", 32'(o_PMDATA), 32'h0);
        check("rst_ready",  32'(o_ld_ready), 32'h0);
        check("rst_busy",   32'(o_ld_busy), 32'h0);
        check("rst_done",   32'(o_ld_done), 32'h0);
        check("rst_err",    32'(o_ld_err), 32'h0);
        check("rst_count",  32'(o_ld_count), 32'h0);
        i_reset = 1'b0;
        tick();

        // Preload six words, mem[5] = 940C.
        start_pulse();
        send_byte(8'h06); send_byte(8'h00);
        for (int i = 0; i < 6; i++) begin
            send_byte(img[i][7:0]);
            send_byte(img[i][15:8]);
        end
        check("pre_done", 32'(o_ld_done), 32'h1);
        check("pre_count", 32'(o_ld_count), 32'd6);
        tick();
        check("pre_done_clr", 32'(o_ld_done), 32'h0);
        check("pre_busy_clr", 32'(o_ld_busy), 32'h0);
        fetch("fetch_a5", 16'd5, 16'h940C);
        fetch("fetch_a0_pre", 16'd0, 16'hA5A5);

        // Two-word load with fetch of address 0 every cycle.
        i_PMADDR = 16'd0;
        done_cnt = 0;
        mon_prev = 1'b0;
        mon_en   = 1'b1;
        start_pulse();
        check("ld_busy", 32'(o_ld_busy), 32'h1);
        check("ld_ready", 32'(o_ld_ready), 32'h1);
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78); send_byte(8'h56);
        check("ld_done", 32'(o_ld_done), 32'h1);
        tick();
        check("ld_busy_fall", 32'(o_ld_busy), 32'h0);
        tick();
        mon_en = 1'b0;
        check("fetch_at_fall", 32'(o_PMDATA), 32'h1234);
        check("ld_done_once", 32'(done_cnt), 32'd1);
        check("ld_count", 32'(o_ld_count), 32'd2);
        fetch("fetch_a1", 16'd1, 16'h5678);
        fetch("fetch_a0", 16'd0, 16'h1234);

        // Oversized length 0x0201.
        done_cnt = 0;
        start_pulse();
        send_byte(8'h01); send_byte(8'h02);
        check("err_set", 32'(o_ld_err), 32'h1);
        check("err_busy", 32'(o_ld_busy), 32'h0);
        check("err_nodone", 32'(o_ld_done), 32'h0);
        tick();
        check("err_nodone_cnt", 32'(done_cnt), 32'd0);
        fetch("err_nowrite", 16'd0, 16'h1234);
        start_pulse();
        check("err_cleared", 32'(o_ld_err), 32'h0);

        // Zero length in that session.
        send_byte(8'h00); send_byte(8'h00);
        check("zero_done", 32'(o_ld_done), 32'h1);
        check("zero_count", 32'(o_ld_count), 32'd0);
        tick();
        check("zero_idle", 32'(o_ld_busy), 32'h0);

        // Source stalls mid-word.
        start_pulse();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h34); send_byte(8'h12);
        send_byte(8'h78);
        repeat (3) tick();
        check("stall_count", 32'(o_ld_count), 32'd1);
        check("stall_busy", 32'(o_ld_busy), 32'h1);
        send_byte(8'h56);
        check("stall_done", 32'(o_ld_done), 32'h1);
        check("stall_count_end", 32'(o_ld_count), 32'd2);
        tick();
        fetch("stall_a0", 16'd0, 16'h1234);
        fetch("stall_a1", 16'd1, 16'h5678);
        fetch("stall_a2", 16'd2, 16'h0002);

        // Reset after three data bytes of a two-word load.
        start_pulse();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'hCD); send_byte(8'hAB);
        send_byte(8'hEF);
        i_reset = 1'b1;
        tick();
        i_reset = 1'b0;
        check("mid_rst_busy", 32'(o_ld_busy), 32'h0);
        check("mid_rst_ready", 32'(o_ld_ready), 32'h0);
        check("mid_rst_done", 32'(o_ld_done), 32'h0);
        check("mid_rst_err", 32'(o_ld_err), 32'h0);
        check("mid_rst_count", 32'(o_ld_count), 32'h0);
        fetch("mid_rst_a0", 16'd0, 16'hABCD);
        fetch("mid_rst_a1", 16'd1, 16'h5678);
        fetch("wrap_0105", 16'h0105, 16'h940C);

        // Length exactly DEPTH fills every word.
        start_pulse();
        send_byte(8'h00); send_byte(8'h01);
        for (int i = 0; i < 256; i++) begin
            send_byte(8'(i));
            send_byte(~8'(i));
        end
        check("full_done", 32'(o_ld_done), 32'h1);
        check("full_count", 32'(o_ld_count), 32'd256);
        check("full_err", 32'(o_ld_err), 32'h0);
        tick();
        fetch("full_a5", 16'd5, 16'hFA05);
        fetch("full_aff", 16'd255, 16'h00FF);
        fetch("full_a0", 16'd0, 16'hFF00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
